// File: rtl/drive_cmd_conditioner.sv
// Synchronises and debounces the driving command buttons and obstacle detectors and holds one command until acknowledged.
// Optional CMD_PRIORITY_EN: resolve simultaneous presses as straight > left > right instead of dropping them.
module drive_cmd_conditioner #(
   parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000,
   parameter logic [31:0] CMD_TIMEOUT     = 32'd100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_straight_raw,
   input  logic btn_left_raw,
   input  logic btn_right_raw,
   input  logic det_front_raw,
   input  logic det_back_raw,
   input  logic det_left_raw,
   input  logic det_right_raw,
   input  logic ready,
   output logic go_straight_command,
   output logic turn_left_command,
   output logic turn_right_command,
   output logic front_detector,
   output logic back_detector,
   output logic left_detector,
   output logic right_detector,
   output logic cmd_pending,
   output logic cmd_dropped
);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK, RELEASE} state_t;

   // Bits 2:0 are the buttons (straight, left, right), bits 6:3 the detectors.
   logic [6:0] raw_vec;
   logic [6:0] deb_vec;

   assign raw_vec = {det_right_raw, det_left_raw, det_back_raw, det_front_raw,
                     btn_right_raw, btn_left_raw, btn_straight_raw};

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_chan
         logic        sync1_q;
         logic        sync2_q;
         logic        deb_q;
         logic        deb_d;
         logic [31:0] cnt_q;
         logic [31:0] cnt_d;

         always_comb begin
            deb_d = deb_q;
            cnt_d = 32'd0;
            if (sync2_q != deb_q) begin
               if (cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
                  deb_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               deb_q   <= 1'b0;
               cnt_q   <= 32'd0;
            end else begin
               sync1_q <= raw_vec[gi];
               sync2_q <= sync1_q;
               deb_q   <= deb_d;
               cnt_q   <= cnt_d;
            end
         end

         assign deb_vec[gi] = deb_q;
      end
   endgenerate

   logic [2:0]  btn_prev_q;
   logic [2:0]  press_q;
   state_t      state_q, state_d;
   logic [2:0]  cmd_q, cmd_d;
   logic        pending_q, pending_d;
   logic        drop_q, drop_d;
   logic [31:0] tcnt_q, tcnt_d;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      pending_d = pending_q;
      drop_d    = 1'b0;
      tcnt_d    = 32'd0;
      case (state_q)
         IDLE: begin
            cmd_d     = 3'b000;
            pending_d = 1'b0;
            if (press_q != 3'b000) begin
`ifdef CMD_PRIORITY_EN
               cmd_d     = press_q[0] ? 3'b001 : (press_q[1] ? 3'b010 : 3'b100);
               pending_d = 1'b1;
               state_d   = ISSUE;
`else
               if ((press_q & (press_q - 3'd1)) == 3'd0) begin
                  cmd_d     = press_q;
                  pending_d = 1'b1;
                  state_d   = ISSUE;
               end else begin
                  drop_d = 1'b1;
               end
`endif
            end
         end
         ISSUE: begin
            if (ready) begin
               state_d = ACK;
            end else if (tcnt_q == CMD_TIMEOUT - 32'd1) begin
               cmd_d     = 3'b000;
               pending_d = 1'b0;
               drop_d    = 1'b1;
               state_d   = RELEASE;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         ACK: begin
            cmd_d     = 3'b000;
            pending_d = 1'b0;
            state_d   = RELEASE;
         end
         default: begin
            // Wait for every button to be released so a held button cannot re-issue.
            cmd_d     = 3'b000;
            pending_d = 1'b0;
            if (deb_vec[2:0] == 3'b000) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_prev_q <= 3'b000;
         press_q    <= 3'b000;
         state_q    <= IDLE;
         cmd_q      <= 3'b000;
         pending_q  <= 1'b0;
         drop_q     <= 1'b0;
         tcnt_q     <= 32'd0;
      end else begin
         btn_prev_q <= deb_vec[2:0];
         press_q    <= deb_vec[2:0] & ~btn_prev_q;
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
         tcnt_q     <= tcnt_d;
      end
   end

   assign go_straight_command = cmd_q[0];
   assign turn_left_command   = cmd_q[1];
   assign turn_right_command  = cmd_q[2];
   assign front_detector      = deb_vec[3];
   assign back_detector       = deb_vec[4];
   assign left_detector       = deb_vec[5];
   assign right_detector      = deb_vec[6];
   assign cmd_pending         = pending_q;
   assign cmd_dropped         = drop_q;

endmodule

// File: tb/tb_drive_cmd_conditioner.sv
// Directed bench for drive_cmd_conditioner with DEBOUNCE_CYCLES=4, CMD_TIMEOUT=16.
module tb_drive_cmd_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_straight_raw = 1'b0;
   logic btn_left_raw = 1'b0;
   logic btn_right_raw = 1'b0;
   logic det_front_raw = 1'b0;
   logic det_back_raw = 1'b0;
   logic det_left_raw = 1'b0;
   logic det_right_raw = 1'b0;
   logic ready = 1'b0;
   logic go_straight_command, turn_left_command, turn_right_command;
   logic front_detector, back_detector, left_detector, right_detector;
   logic cmd_pending, cmd_dropped;

   int passed = 0;
   int total = 0;
   int fails = 0;

`ifdef CMD_PRIORITY_EN
   localparam logic PRIO = 1'b1;
`else
   localparam logic PRIO = 1'b0;
`endif

   drive_cmd_conditioner #(
      .DEBOUNCE_CYCLES(32'd4),
      .CMD_TIMEOUT    (32'd16)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .btn_straight_raw   (btn_straight_raw),
      .btn_left_raw       (btn_left_raw),
      .btn_right_raw      (btn_right_raw),
      .det_front_raw      (det_front_raw),
      .det_back_raw       (det_back_raw),
      .det_left_raw       (det_left_raw),
      .det_right_raw      (det_right_raw),
      .ready              (ready),
      .go_straight_command(go_straight_command),
      .turn_left_command  (turn_left_command),
      .turn_right_command (turn_right_command),
      .front_detector     (front_detector),
      .back_detector      (back_detector),
      .left_detector      (left_detector),
      .right_detector     (right_detector),
      .cmd_pending        (cmd_pending),
      .cmd_dropped        (cmd_dropped)
   );

   always #5 clk = ~clk;

   logic [8:0] outs;
   assign outs = {cmd_pending, cmd_dropped, go_straight_command, turn_left_command,
                  turn_right_command, front_detector, back_detector, left_detector,
                  right_detector};

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int hi_cnt;
      int drop_cnt;
      int drop_at;
      int other_cnt;

      // Reset state
      step(3);
      chk("reset_outputs", {23'd0, outs}, 32'd0);
      rst = 1'b1;
      step(2);
      chk("after_release_idle", {23'd0, outs}, 32'd0);

      // Reset asserted in the middle of an issued command
      btn_right_raw = 1'b1;
      ready = 1'b0;
      step(10);
      chk("pre_reset_pending", {31'd0, cmd_pending}, 32'd1);
      chk("pre_reset_right", {31'd0, turn_right_command}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_clear", {23'd0, outs}, 32'd0);
      btn_right_raw = 1'b0;
      step(2);
      chk("held_reset_clear", {23'd0, outs}, 32'd0);
      rst = 1'b1;
      hi_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (cmd_pending) hi_cnt++;
      end
      chk("no_cmd_after_reset", hi_cnt, 32'd0);

      // Clean left press with ready high
      ready = 1'b1;
      btn_left_raw = 1'b1;
      step(7);
      chk("left_before_latency", {31'd0, turn_left_command}, 32'd0);
      step(1);
      chk("left_at_8", {29'd0, go_straight_command, turn_left_command, turn_right_command}, 32'd2);
      chk("left_pending", {31'd0, cmd_pending}, 32'd1);
      step(1);
      chk("left_at_9", {31'd0, turn_left_command}, 32'd1);
      step(1);
      chk("left_at_10", {31'd0, turn_left_command}, 32'd0);
      chk("left_pending_clear", {31'd0, cmd_pending}, 32'd0);
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (turn_left_command || cmd_pending) hi_cnt++;
      end
      chk("left_no_reissue", hi_cnt, 32'd0);
      btn_left_raw = 1'b0;
      step(12);

      // Bouncing straight button
      hi_cnt = 0;
      drop_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         btn_straight_raw = ~btn_straight_raw;
         for (int j = 0; j < 2; j++) begin
            step(1);
            if (go_straight_command) hi_cnt++;
            if (cmd_dropped) drop_cnt++;
         end
      end
      btn_straight_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (go_straight_command) hi_cnt++;
         if (cmd_dropped) drop_cnt++;
      end
      chk("bounce_no_straight", hi_cnt, 32'd0);
      chk("bounce_no_drop", drop_cnt, 32'd0);

      // Right press never acknowledged
      ready = 1'b0;
      btn_right_raw = 1'b1;
      step(7);
      chk("right_before_latency", {31'd0, turn_right_command}, 32'd0);
      hi_cnt = 0;
      drop_cnt = 0;
      drop_at = -1;
      other_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         step(1);
         if (turn_right_command) hi_cnt++;
         if (go_straight_command || turn_left_command) other_cnt++;
         if (cmd_dropped) begin
            drop_cnt++;
            drop_at = i;
         end
      end
      chk("right_high_cycles", hi_cnt, 32'd16);
      chk("right_drop_count", drop_cnt, 32'd1);
      chk("right_drop_cycle", drop_at, 32'd16);
      chk("right_onehot", other_cnt, 32'd0);
      chk("right_cleared", {23'd0, outs}, 32'd0);
      btn_right_raw = 1'b0;
      step(12);

      // Simultaneous straight and left
      ready = 1'b1;
      btn_straight_raw = 1'b1;
      btn_left_raw = 1'b1;
      step(8);
      chk("conflict_drop_at_8", {31'd0, cmd_dropped}, {31'd0, ~PRIO});
      chk("conflict_straight_at_8", {31'd0, go_straight_command}, {31'd0, PRIO});
      hi_cnt = 1;
      if (!go_straight_command) hi_cnt = 0;
      drop_cnt = cmd_dropped ? 1 : 0;
      other_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (go_straight_command) hi_cnt++;
         if (turn_left_command || turn_right_command) other_cnt++;
         if (cmd_dropped) drop_cnt++;
      end
      chk("conflict_straight_cycles", hi_cnt, PRIO ? 32'd2 : 32'd0);
      chk("conflict_left_never", other_cnt, 32'd0);
      chk("conflict_drop_count", drop_cnt, PRIO ? 32'd0 : 32'd1);
      btn_straight_raw = 1'b0;
      btn_left_raw = 1'b0;
      step(12);

      // Front detector glitch, then a real pulse
      det_front_raw = 1'b1;
      step(3);
      det_front_raw = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (front_detector) hi_cnt++;
      end
      chk("front_glitch_ignored", hi_cnt, 32'd0);
      det_front_raw = 1'b1;
      step(5);
      chk("front_at_5", {31'd0, front_detector}, 32'd0);
      step(1);
      chk("front_at_6", {31'd0, front_detector}, 32'd1);
      chk("other_detectors", {29'd0, back_detector, left_detector, right_detector}, 32'd0);
      step(4);
      det_front_raw = 1'b0;
      step(5);
      chk("front_fall_at_5", {31'd0, front_detector}, 32'd1);
      step(1);
      chk("front_fall_at_6", {31'd0, front_detector}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
